io_word_sequencer: RTL

IO_WORD_SEQUENCER -- requirements
Module: io_word_sequencer

---
 rtl/io_seq_pkg.sv | 10 +
 rtl/io_word_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/io_seq_pkg.sv
// Shared types for the IO word sequencer and the blocks that sit around it.
package io_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } seq_state_e;

endpackage

// File: rtl/io_word_sequencer.sv
// Frames one word at a time through an externally instantiated shift register:
// aligns TX data on load, counts len+1 bit ticks, then aligns and buffers the RX word.
module io_word_sequencer
   import io_seq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   localparam int unsigned LEN_W = $clog2(DATA_WIDTH)
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [LEN_W-1:0]      cfg_len_i,
   input  logic                  cfg_lsbfirst_i,
   input  logic                  abort_i,
   input  logic                  bit_en_i,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   input  logic                  rx_ready_i,
   output logic [DATA_WIDTH-1:0] sr_data_o,
   output logic                  sr_load_o,
   output logic                  sr_shift_o,
   output logic                  sr_lsbfirst_o,
   input  logic [DATA_WIDTH-1:0] sr_data_i,
   output logic                  busy_o
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH - 1);

   seq_state_e            state_q, state_d;
   logic [LEN_W-1:0]      cnt_q, cnt_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic                  lsb_q, lsb_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic [LEN_W-1:0]      cfg_len_clamped;
   logic [LEN_W-1:0]      rx_shamt;
   logic [DATA_WIDTH-1:0] rx_word;
   logic                  tx_ready_c;

   // A clamp is only needed when the length field can exceed DATA_WIDTH-1.
   if ((2 ** LEN_W) == DATA_WIDTH) begin : g_no_clamp
      assign cfg_len_clamped = cfg_len_i;
   end else begin : g_clamp
      assign cfg_len_clamped = (cfg_len_i > MAX_LEN) ? MAX_LEN : cfg_len_i;
   end

   // Undo the load alignment: MSB-first frames land low, LSB-first frames land high.
   assign rx_shamt = MAX_LEN - len_q;
   assign rx_word  = lsb_q ? (sr_data_i >> rx_shamt)
                           : (sr_data_i & ({DATA_WIDTH{1'b1}} >> rx_shamt));

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      len_d         = len_q;
      lsb_d         = lsb_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q;
      tx_ready_c    = 1'b0;
      sr_load_o     = 1'b0;
      sr_shift_o    = 1'b0;
      sr_data_o     = '0;
      sr_lsbfirst_o = lsb_q;

      if (rx_valid_q && rx_ready_i) begin
         rx_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            sr_lsbfirst_o = cfg_lsbfirst_i;
            tx_ready_c    = rstn_i && (!rx_valid_q || rx_ready_i);
            sr_data_o     = cfg_lsbfirst_i ? tx_data_i
                                           : (tx_data_i << (MAX_LEN - cfg_len_clamped));
            if (tx_ready_c && tx_valid_i) begin
               sr_load_o = 1'b1;
               len_d     = cfg_len_clamped;
               lsb_d     = cfg_lsbfirst_i;
               cnt_d     = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            sr_shift_o = rstn_i && bit_en_i;
            if (abort_i) begin
               state_d = IDLE;
            end else if (bit_en_i) begin
               cnt_d = cnt_q + LEN_W'(1);
               if (cnt_q == len_q) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            if (!abort_i) begin
               rx_data_d  = rx_word;
               rx_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         lsb_q      <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         lsb_q      <= lsb_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign tx_ready_o = tx_ready_c;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign busy_o     = rstn_i && (state_q != IDLE);

endmodule
